alu_seq_unit: RTL and testbench
===============================

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 The block SHALL have this parameter: XLEN, default 32, datapath width in bits.
REQ-002 The block SHALL have the port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port valid_i, input, 1 bit: operation request valid.
REQ-005 The block SHALL have the port ready_o, output, 1 bit: unit can accept an operation this cycle.
REQ-006 The block SHALL have the port alu_control_i, input, 4 bits: op code from the ALU decoder (0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 SRL, 6 SRA, 7 OR, 8 XOR, 9 AND, A zero).
REQ-007 The block SHALL have the ports src_a_i and src_b_i, input, XLEN bits each: operands.
REQ-008 The block SHALL have the port valid_o, output, 1 bit: result_o holds a completed result.
REQ-009 The block SHALL have the port ready_i, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have the port result_o, output, XLEN bits: registered result.
REQ-011 The block SHALL have the port zero_o, output, 1 bit: combinational (result_o == 0), used for branch compare.

Function
REQ-012 The block SHALL implement three states: IDLE, SHIFT and HOLD.
REQ-013 Handshake: the block SHALL accept an operation when valid_i && ready_o; opcode and operands are captured at acceptance, and later input changes are ignored.
REQ-014 ready_o SHALL be 1 in IDLE, equal ready_i in HOLD, and 0 in SHIFT.
REQ-015 Non-shift ops (0,1,3,4,7,8,9,A) and codes B-F SHALL write the result into result_o and enter HOLD on the accepting edge (latency 1 cycle); codes B-F SHALL produce 0.
REQ-016 Arithmetic SHALL wrap modulo 2^XLEN; SLT SHALL compare signed and SLTU unsigned, with result 1 or 0 zero-extended.
REQ-017 Shift ops (2,5,6) SHALL use shamt = src_b_i[4:0]; if shamt == 0, result_o = src_a_i and the block enters HOLD after 1 cycle.
REQ-018 For a shift with shamt > 0, the block SHALL load src_a_i into the shift register, set a 5-bit counter to shamt and enter SHIFT.
REQ-019 In SHIFT the block SHALL shift one bit per cycle (SLL fills 0, SRL fills 0, SRA replicates the MSB) and decrement the counter; when the counter reaches 1 it performs the final shift and enters HOLD.
REQ-020 Total shift latency SHALL be shamt+1 cycles from acceptance to valid_o.
REQ-021 HOLD: valid_o SHALL be 1 and result_o stable until ready_i; with ready_i && !valid_i the block SHALL return to IDLE.
REQ-022 HOLD with ready_i && valid_i SHALL retire the current result and accept the new op on the same edge (back-to-back, no bubble).
REQ-023 valid_o SHALL be 0 in IDLE and SHIFT.
REQ-024 result_o SHALL hold its last value in IDLE.

Reset
REQ-025 While rst_i is high, the block SHALL be in state IDLE with valid_o=0, ready_o=1, result_o=0, zero_o=1, and the counter and shift register at 0.
REQ-026 Reset asserted mid-SHIFT or mid-HOLD SHALL abandon the operation immediately; no result is delivered.
REQ-027 Release of rst_i SHALL allow acceptance on the first rising edge after release.

Configuration
REQ-028 The block SHALL support the macro FAST_SHIFT_EN.
REQ-029 With FAST_SHIFT_EN defined, the block SHALL execute shifts through a barrel shifter with 1-cycle latency like other ops; the SHIFT state SHALL be unreachable and ready_o SHALL never be 0 outside HOLD.
REQ-030 Without FAST_SHIFT_EN, shifts SHALL be iterative as in REQ-018 to REQ-020.

Verification
REQ-031 Bench SHALL cover: ADD 0xFFFFFFFF + 1, ready_i=1 -> valid_o one cycle later, result_o=0, zero_o=1.
REQ-032 Bench SHALL cover: SLT 0xFFFFFFFF vs 1 -> 1; SLTU with the same operands -> 0.
REQ-033 Bench SHALL cover: SRA 0x80000000 by 4 (no FAST_SHIFT_EN) -> ready_o=0 for 4 cycles, valid_o at cycle 5, result_o=0xF8000000; with FAST_SHIFT_EN -> valid_o at cycle 1.
REQ-034 Bench SHALL cover: SLL with shamt=0 and src_a=0x1234 -> result_o=0x1234 after 1 cycle.
REQ-035 Bench SHALL cover: in HOLD with ready_i=0 for 3 cycles -> result_o stable and valid_o=1; then ready_i=1 with valid_i=1 carrying SUB 5-5 -> next cycle result_o=0, zero_o=1.
REQ-036 Bench SHALL cover: rst_i pulsed during SRL by 20 at cycle 7 -> valid_o=0, result_o=0 and ready_o=1 immediately; no stale result is delivered after release.

Source files
------------

// File: rtl/alu_seq_unit.sv
// Sequential ALU with a valid/ready handshake on both sides; shifts run one bit per cycle.
// Optional macro FAST_SHIFT_EN replaces the iterative shifter with a single-cycle barrel shifter.
module alu_seq_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      alu_control_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLL  = 4'h2;
  localparam logic [3:0] OP_SLT  = 4'h3;
  localparam logic [3:0] OP_SLTU = 4'h4;
  localparam logic [3:0] OP_SRL  = 4'h5;
  localparam logic [3:0] OP_SRA  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_AND  = 4'h9;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] shreg_q, shreg_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] shifted_s;
  logic            accept_s;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // Single-bit step of the iterative shifter; SRA replicates the sign bit.
  function automatic logic [XLEN-1:0] shift_one(input logic [3:0] op, input logic [XLEN-1:0] v);
    case (op)
      OP_SLL:  return {v[XLEN-2:0], 1'b0};
      OP_SRA:  return {v[XLEN-1], v[XLEN-1:1]};
      default: return {1'b0, v[XLEN-1:1]};
    endcase
  endfunction

  function automatic logic [XLEN-1:0] alu_calc(input logic [3:0] op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
`ifdef FAST_SHIFT_EN
    logic [4:0] shamt;
    shamt = b[4:0];
`endif
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_AND:  return a & b;
`ifdef FAST_SHIFT_EN
      OP_SLL:  return a << shamt;
      OP_SRL:  return a >> shamt;
      OP_SRA:  return $signed(a) >>> shamt;
`else
      // Only reached with a zero shift amount; longer shifts go through SHIFT.
      OP_SLL, OP_SRL, OP_SRA: return a;
`endif
      default: return {XLEN{1'b0}};
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    ready_o   = 1'b0;
    valid_o   = 1'b0;
    shifted_s = shift_one(op_q, shreg_q);
    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
      end
      S_HOLD: begin
        ready_o = ready_i;
        valid_o = 1'b1;
        if (ready_i && !valid_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_SHIFT: begin
        shreg_d = shifted_s;
        cnt_d   = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          result_d = shifted_s;
          state_d  = S_HOLD;
        end else begin
          state_d = S_SHIFT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    accept_s = valid_i && ready_o;
    // A new request overrides the HOLD->IDLE decision, giving back-to-back issue.
    if (accept_s) begin
`ifdef FAST_SHIFT_EN
      result_d = alu_calc(alu_control_i, src_a_i, src_b_i);
      state_d  = S_HOLD;
`else
      if (is_shift(alu_control_i) && (src_b_i[4:0] != 5'd0)) begin
        shreg_d = src_a_i;
        cnt_d   = src_b_i[4:0];
        op_d    = alu_control_i;
        state_d = S_SHIFT;
      end else begin
        result_d = alu_calc(alu_control_i, src_a_i, src_b_i);
        state_d  = S_HOLD;
      end
`endif
    end else begin
      op_d = op_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      result_q <= {XLEN{1'b0}};
      shreg_q  <= {XLEN{1'b0}};
      cnt_q    <= 5'd0;
      op_q     <= 4'd0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
    end
  end

  assign result_o = result_q;
  assign zero_o   = (result_q == {XLEN{1'b0}});

endmodule

// File: tb/tb_alu_seq_unit.sv
// Randomized + directed bench for alu_seq_unit against a spec-level reference model.
module tb_alu_seq_unit;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  alu_control_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        zero_o;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq_unit #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .alu_control_i(alu_control_i), .src_a_i(src_a_i), .src_b_i(src_b_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .zero_o(zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a << sh;
      4'h3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h4: return (a < b) ? 32'd1 : 32'd0;
      4'h5: return a >> sh;
      4'h6: return $signed(a) >>> sh;
      4'h7: return a | b;
      4'h8: return a ^ b;
      4'h9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
`ifdef FAST_SHIFT_EN
    return 1;
`else
    if ((op == 4'h2 || op == 4'h5 || op == 4'h6) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Issue one op from IDLE, scramble inputs after acceptance, measure latency and check result.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int cycles;
    logic [31:0] exp;
    exp = ref_result(op, a, b);
    @(negedge clk_i);
    ready_i = 1'b1;
    valid_i = 1'b1;
    alu_control_i = op;
    src_a_i = a;
    src_b_i = b;
    #1 check_eq({tag, "_rdy_idle"}, {31'd0, ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    alu_control_i = 4'($urandom_range(0, 15));
    src_a_i = $urandom;
    src_b_i = $urandom;
    cycles = 1;
    @(negedge clk_i);
    while (!valid_o && cycles < 64) begin
      check_eq({tag, "_rdy_busy"}, {31'd0, ready_o}, 32'd0);
      @(negedge clk_i);
      cycles++;
    end
    check_eq({tag, "_lat"}, 32'(cycles), 32'(ref_latency(op, b)));
    check_eq({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    check_eq({tag, "_res"}, result_o, exp);
    check_eq({tag, "_zero"}, {31'd0, zero_o}, {31'd0, (exp == 32'd0)});
  endtask

  initial begin
    int stale;
    logic [31:0] held;
    logic [3:0] rop;
    logic [31:0] ra, rb;
    rst_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    alu_control_i = 4'd0;
    src_a_i = 32'd0;
    src_b_i = 32'd0;
    repeat (2) @(negedge clk_i);
    check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
    check_eq("rst_ready", {31'd0, ready_o}, 32'd1);
    check_eq("rst_result", result_o, 32'd0);
    check_eq("rst_zero", {31'd0, zero_o}, 32'd1);
    rst_i = 1'b0;

    run_op("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'd1);
    run_op("slt", 4'h3, 32'hFFFF_FFFF, 32'd1);
    run_op("sltu", 4'h4, 32'hFFFF_FFFF, 32'd1);
    run_op("sra4", 4'h6, 32'h8000_0000, 32'd4);
    run_op("sll0", 4'h2, 32'h0000_1234, 32'd0);
    run_op("srl31", 4'h5, 32'h8000_0001, 32'd31);
    run_op("sll1", 4'h2, 32'hC000_0001, 32'd1);
    run_op("op_a", 4'hA, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op("op_f", 4'hF, 32'h1234_5678, 32'h9ABC_DEF0);

    // Stall in HOLD, then retire and accept SUB 5-5 on the same edge.
    @(negedge clk_i);
    ready_i = 1'b0;
    valid_i = 1'b1;
    alu_control_i = 4'h0;
    src_a_i = 32'h10;
    src_b_i = 32'h22;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_eq("hold_valid", {31'd0, valid_o}, 32'd1);
      check_eq("hold_res", result_o, 32'h32);
      check_eq("hold_rdy", {31'd0, ready_o}, 32'd0);
    end
    ready_i = 1'b1;
    valid_i = 1'b1;
    alu_control_i = 4'h1;
    src_a_i = 32'd5;
    src_b_i = 32'd5;
    #1 check_eq("b2b_rdy", {31'd0, ready_o}, 32'd1);
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("b2b_valid", {31'd0, valid_o}, 32'd1);
    check_eq("b2b_res", result_o, 32'd0);
    check_eq("b2b_zero", {31'd0, zero_o}, 32'd1);
    @(negedge clk_i);
    check_eq("b2b_idle", {31'd0, valid_o}, 32'd0);
    held = result_o;
    @(negedge clk_i);
    check_eq("idle_keep", result_o, held);

    // Reset in the middle of a long SRL (or in HOLD for the fast build).
    run_op("pre_rst", 4'h8, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
    @(negedge clk_i);
    ready_i = 1'b0;
    valid_i = 1'b1;
    alu_control_i = 4'h5;
    src_a_i = 32'hFFFF_0000;
    src_b_i = 32'd20;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    repeat (6) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_eq("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    check_eq("mid_rst_res", result_o, 32'd0);
    check_eq("mid_rst_rdy", {31'd0, ready_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    ready_i = 1'b1;
    stale = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk_i);
      if (valid_o) stale++;
    end
    check_eq("no_stale", 32'(stale), 32'd0);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      rb = $urandom;
      if ($urandom_range(0, 4) == 0) rb[4:0] = 5'd0;
      run_op("rnd", rop, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
